// File: rtl/cep_dout_ctrl_pkg.sv
// cep_dout_ctrl_pkg: shared types for the CEP dout read sequencer
//   cpuOpT     - CPU request encodings (READ / READCLEAR)
//   ctrlStateT - sequencer FSM states
//   readTagT   - per-read tag carried down the dout delay lines
//   satInc     - saturating 8-bit increment for the starvation counter
package cep_dout_ctrl_pkg;

    typedef enum logic {
        OP_READ      = 1'b0,
        OP_READCLEAR = 1'b1
    } cpuOpT;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        RD_INFLIGHT,
        CLR_PEND
    } ctrlStateT;

    typedef struct packed {
        logic valid;
        logic isHw;
        logic bypass;
    } readTagT;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cep_read_tag_delay.sv
// cep_read_tag_delay: shift register of read tags with two delay taps
//   sysClk, reset - clock and synchronous active-high flush
//   tagIn         - tag of the access issued this cycle
//   tapA / tapB   - tagIn delayed by TAP_A / TAP_B cycles (each >= 1)
module cep_read_tag_delay
    import cep_dout_ctrl_pkg::*;
#(
    parameter int TAP_A = 1,
    parameter int TAP_B = 1
) (
    input  logic    sysClk,
    input  logic    reset,
    input  readTagT tagIn,
    output readTagT tapA,
    output readTagT tapB
);

    localparam int DEPTH = (TAP_A > TAP_B) ? TAP_A : TAP_B;

    readTagT stages [DEPTH];

    always_ff @(posedge sysClk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tagIn;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign tapA = stages[TAP_A-1];
    assign tapB = stages[TAP_B-1];

endmodule

// File: rtl/cep_dout_read_ctrl.sv
// cep_dout_read_ctrl: shares a single-port CEP memory between hw reads and one CPU READ/READCLEAR
//   hwRead/hwAddr/hwStall           - hardware client, always granted in the same cycle
//   cpuReq/cpuOp/cpuAddr/cpuReady   - CPU request handshake
//   cpuRspValid/cpuRspUncErr/CorErr - CPU response strobe with captured checker errors
//   uncErr/corErr                   - checker outputs
//   memRe/memWe/memAddr             - memory port (write data is always zero)
//   hwReadAtGate/parityPipeReadValid/gatedCpuBypass0sToHwRead - dout pipeline enables
module cep_dout_read_ctrl
    import cep_dout_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH          = 10,
    parameter int CAP_NUMWORDENABLES = 1,
    parameter int GATE_OFFSET        = 1,
    parameter int RD_LATENCY         = 2,
    parameter int HW_LATENCY         = 2,
    parameter int STARVE_LIMIT       = 15
) (
    input  logic                          sysClk,
    input  logic                          reset,
    input  logic                          hwRead,
    input  logic [ADDRWIDTH-1:0]          hwAddr,
    output logic                          hwStall,
    input  logic                          cpuReq,
    input  logic                          cpuOp,
    input  logic [ADDRWIDTH-1:0]          cpuAddr,
    output logic                          cpuReady,
    output logic                          cpuRspValid,
    output logic [CAP_NUMWORDENABLES-1:0] cpuRspUncErr,
    output logic [CAP_NUMWORDENABLES-1:0] cpuRspCorErr,
    input  logic [CAP_NUMWORDENABLES-1:0] uncErr,
    input  logic [CAP_NUMWORDENABLES-1:0] corErr,
    output logic                          memRe,
    output logic                          memWe,
    output logic [ADDRWIDTH-1:0]          memAddr,
    output logic                          hwReadAtGate,
    output logic                          parityPipeReadValid,
    output logic [CAP_NUMWORDENABLES-1:0] gatedCpuBypass0sToHwRead
);

    ctrlStateT                     state, stateNext;
    logic [7:0]                    waitCnt, waitCntNext;
    logic [ADDRWIDTH-1:0]          clrAddr;
    logic                          clrPend, rspPend;
    logic [CAP_NUMWORDENABLES-1:0] heldUnc, heldCor;
    logic                          cpuIssue, clrIssue;
    readTagT                       issueTag, gateTag, unusedGateTapB, hwTag, rdTag;
    logic                          unusedTagBits;

    // Hw reads always win the port; CPU read and zero write only take idle slots.
    assign cpuIssue = !reset && state == WAIT_SLOT && !hwRead;
    assign clrIssue = !reset && state == CLR_PEND && !hwRead;
    assign memRe    = hwRead || cpuIssue;
    assign memWe    = clrIssue;
    assign memAddr  = hwRead ? hwAddr : cpuIssue ? cpuAddr : clrIssue ? clrAddr : '0;
    assign cpuReady = cpuIssue;

    // clrPend is high exactly over the clear window, so a matching hw read gets zero-bypassed.
    assign issueTag = '{valid: memRe, isHw: hwRead, bypass: hwRead && clrPend && hwAddr == clrAddr};

    cep_read_tag_delay #(.TAP_A(GATE_OFFSET), .TAP_B(GATE_OFFSET)) gateLine (
        .sysClk(sysClk), .reset(reset), .tagIn(issueTag), .tapA(gateTag), .tapB(unusedGateTapB)
    );

    cep_read_tag_delay #(.TAP_A(HW_LATENCY), .TAP_B(RD_LATENCY)) latLine (
        .sysClk(sysClk), .reset(reset), .tagIn(issueTag), .tapA(hwTag), .tapB(rdTag)
    );

    assign unusedTagBits = ^{unusedGateTapB, gateTag.bypass, rdTag.bypass};

    assign parityPipeReadValid      = gateTag.valid;
    assign hwReadAtGate             = gateTag.valid && gateTag.isHw;
    assign cpuRspValid              = rdTag.valid && !rdTag.isHw;
    assign gatedCpuBypass0sToHwRead = {CAP_NUMWORDENABLES{hwTag.valid && hwTag.isHw && hwTag.bypass}};
    // Errors pass through on the strobe cycle and are held afterwards.
    assign cpuRspUncErr             = cpuRspValid ? uncErr : heldUnc;
    assign cpuRspCorErr             = cpuRspValid ? corErr : heldCor;

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE:        stateNext = cpuReq ? WAIT_SLOT : IDLE;
            WAIT_SLOT: begin
                stateNext   = hwRead ? WAIT_SLOT : RD_INFLIGHT;
                waitCntNext = hwRead ? satInc(waitCnt) : 8'd0;
            end
            RD_INFLIGHT: stateNext = clrPend ? CLR_PEND : (rspPend && !cpuRspValid) ? RD_INFLIGHT : IDLE;
            CLR_PEND:    stateNext = hwRead ? CLR_PEND : (rspPend && !cpuRspValid) ? RD_INFLIGHT : IDLE;
            default:     stateNext = IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= '0;
            hwStall <= 1'b0;
            clrAddr <= '0;
            clrPend <= 1'b0;
            rspPend <= 1'b0;
            heldUnc <= '0;
            heldCor <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            hwStall <= stateNext == CLR_PEND || (stateNext == WAIT_SLOT && waitCntNext >= 8'(STARVE_LIMIT));
            if (cpuIssue) begin
                clrAddr <= cpuAddr;
                clrPend <= cpuOp == OP_READCLEAR;
                rspPend <= 1'b1;
            end else begin
                if (clrIssue) clrPend <= 1'b0;
                if (cpuRspValid) rspPend <= 1'b0;
            end
            if (cpuRspValid) begin
                heldUnc <= uncErr;
                heldCor <= corErr;
            end
        end
    end

endmodule

// File: tb/tb_cep_dout_read_ctrl.sv
// tb_cep_dout_read_ctrl: directed and random checks of cep_dout_read_ctrl against a cycle-indexed event model
module tb_cep_dout_read_ctrl;

    localparam int AW = 10, NW = 1, G = 1, RD = 2, HW = 2, LIM = 15;

    logic          sysClk = 0, reset = 1;
    logic          hwRead = 0, cpuReq = 0, cpuOp = 0;
    logic [AW-1:0] hwAddr = '0, cpuAddr = '0;
    logic [NW-1:0] uncErr = '0, corErr = '0;
    logic          hwStall, cpuReady, cpuRspValid, memRe, memWe, hwReadAtGate, parityPipeReadValid;
    logic [NW-1:0] cpuRspUncErr, cpuRspCorErr, gatedCpuBypass0sToHwRead;
    logic [AW-1:0] memAddr;

    always #5 sysClk = ~sysClk;

    cep_dout_read_ctrl #(
        .ADDRWIDTH(AW), .CAP_NUMWORDENABLES(NW), .GATE_OFFSET(G),
        .RD_LATENCY(RD), .HW_LATENCY(HW), .STARVE_LIMIT(LIM)
    ) dut (
        .sysClk(sysClk), .reset(reset), .hwRead(hwRead), .hwAddr(hwAddr), .hwStall(hwStall),
        .cpuReq(cpuReq), .cpuOp(cpuOp), .cpuAddr(cpuAddr), .cpuReady(cpuReady),
        .cpuRspValid(cpuRspValid), .cpuRspUncErr(cpuRspUncErr), .cpuRspCorErr(cpuRspCorErr),
        .uncErr(uncErr), .corErr(corErr), .memRe(memRe), .memWe(memWe), .memAddr(memAddr),
        .hwReadAtGate(hwReadAtGate), .parityPipeReadValid(parityPipeReadValid),
        .gatedCpuBypass0sToHwRead(gatedCpuBypass0sToHwRead)
    );

    int tests = 0, fails = 0, cyc = 0;

    // Future output events, indexed by absolute cycle modulo 64.
    bit expGate [64], expHwGate [64], expRsp [64], expByp [64];
    // Outstanding CPU operation, described by the cycles at which its milestones happen.
    bit            mBusy, mIssued, mOp, mWriteDone;
    int            mAcceptCyc, mIssueCyc, mRspCyc, mWriteCyc, mBlocked;
    logic [AW-1:0] mAddr;
    logic [NW-1:0] mUnc, mCor;
    bit            eStall, eIssue, eWrite;
    logic [AW-1:0] eAddr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic failTimeout(string tag);
        tests++;
        fails++;
        $error("FAIL %s timeout at cycle %0d", tag, cyc);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            expGate[i] = 0; expHwGate[i] = 0; expRsp[i] = 0; expByp[i] = 0;
        end
        mBusy = 0; mIssued = 0; mOp = 0; mWriteDone = 0; mBlocked = 0;
        mUnc = '0; mCor = '0; mAddr = '0;
    endtask

    // Called at posedge+1 with this cycle's inputs already driven.
    task automatic stepCycle();
        int s;
        bit waiting, clrOpen, eRsp, eGate, eHwGate, eByp;
        s = cyc % 64;
        eIssue = 0;
        if (reset) begin
            modelReset();
        end else begin
            if (mBusy && mIssued && mWriteDone && cyc > mRspCyc && cyc > mWriteCyc) mBusy = 0;
            waiting = mBusy && !mIssued && cyc > mAcceptCyc;
            clrOpen = mBusy && mIssued && mOp && !mWriteDone;
            eStall  = (waiting && mBlocked >= LIM) || (clrOpen && cyc >= mIssueCyc + 2);
            eIssue  = waiting && !hwRead;
            eWrite  = clrOpen && cyc >= mIssueCyc + 2 && !hwRead;
            eAddr   = hwRead ? hwAddr : eIssue ? cpuAddr : eWrite ? mAddr : '0;
            eRsp = expRsp[s]; eGate = expGate[s]; eHwGate = expHwGate[s]; eByp = expByp[s];
            expRsp[s] = 0; expGate[s] = 0; expHwGate[s] = 0; expByp[s] = 0;
            if (eRsp) begin mUnc = uncErr; mCor = corErr; end
            if (hwRead || eIssue) begin
                expGate[(cyc + G) % 64]   = 1;
                expHwGate[(cyc + G) % 64] = hwRead;
            end
            if (eIssue) expRsp[(cyc + RD) % 64] = 1;
            if (hwRead && clrOpen && cyc > mIssueCyc && hwAddr == mAddr) expByp[(cyc + HW) % 64] = 1;
            @(negedge sysClk);
            chk("memRe", 32'(memRe), 32'(hwRead || eIssue));
            chk("memWe", 32'(memWe), 32'(eWrite));
            chk("memAddr", 32'(memAddr), 32'(eAddr));
            chk("cpuReady", 32'(cpuReady), 32'(eIssue));
            chk("hwStall", 32'(hwStall), 32'(eStall));
            chk("cpuRspValid", 32'(cpuRspValid), 32'(eRsp));
            chk("cpuRspUncErr", 32'(cpuRspUncErr), 32'(mUnc));
            chk("cpuRspCorErr", 32'(cpuRspCorErr), 32'(mCor));
            chk("parityPipeReadValid", 32'(parityPipeReadValid), 32'(eGate));
            chk("hwReadAtGate", 32'(hwReadAtGate), 32'(eHwGate));
            chk("bypass", 32'(gatedCpuBypass0sToHwRead), 32'({NW{eByp}}));
            if (waiting && hwRead && mBlocked < 255) mBlocked++;
            if (eIssue) begin
                mIssued = 1; mIssueCyc = cyc; mAddr = cpuAddr; mOp = cpuOp;
                mRspCyc = cyc + RD; mWriteCyc = cyc; mWriteDone = !cpuOp;
            end
            if (eWrite) begin mWriteDone = 1; mWriteCyc = cyc; end
            if (!mBusy && cpuReq) begin mBusy = 1; mAcceptCyc = cyc; mIssued = 0; mBlocked = 0; end
        end
        @(posedge sysClk);
        #1;
        cyc++;
        if (eIssue) cpuReq = 0;
    endtask

    task automatic runUntilIdle(string tag, int maxCyc);
        int n = 0;
        while ((mBusy || cpuReq) && n < maxCyc) begin stepCycle(); n++; end
        if (mBusy || cpuReq) failTimeout(tag);
    endtask

    task automatic waitIssue(string tag, int maxCyc);
        int n = 0;
        do begin stepCycle(); n++; end while (!eIssue && n < maxCyc);
        if (!eIssue) failTimeout(tag);
    endtask

    task automatic request(bit op, logic [AW-1:0] addr);
        cpuReq = 1; cpuOp = op; cpuAddr = addr;
    endtask

    initial begin
        int n;
        modelReset();
        @(posedge sysClk);
        #1;
        repeat (3) stepCycle();
        reset = 0;
        repeat (2) stepCycle();

        // Lone CPU READ with an uncorrectable error reported at response time.
        uncErr = 1'b1;
        request(0, 10'h005);
        runUntilIdle("loneRead", 12);
        uncErr = 1'b0;
        repeat (2) stepCycle();

        // Hw client hogs the port until hwStall, then idles.
        request(0, 10'h033);
        hwRead = 1; hwAddr = 10'h010;
        n = 0;
        do begin stepCycle(); n++; end while (!eStall && n < 40);
        if (!eStall) failTimeout("starveStall");
        hwRead = 0;
        runUntilIdle("starveIssue", 10);

        // READCLEAR with hw reads to the cleared address and to a neighbour.
        for (int k = 0; k < 2; k++) begin
            request(1, 10'h020);
            waitIssue("clrIssue", 10);
            hwRead = 1; hwAddr = (k == 0) ? 10'h020 : 10'h021;
            repeat (2) stepCycle();
            hwRead = 0;
            runUntilIdle("clrDone", 12);
            repeat (3) stepCycle();
        end

        // Hw-only traffic.
        for (int k = 0; k < 6; k++) begin
            hwRead = 1; hwAddr = AW'($urandom_range(0, 1023));
            stepCycle();
        end
        hwRead = 0;
        repeat (3) stepCycle();

        // Reset while the READCLEAR read is in flight and its write is pending.
        request(1, 10'h040);
        waitIssue("rstIssue", 10);
        hwRead = 1; hwAddr = 10'h041;
        stepCycle();
        hwRead = 0; reset = 1;
        repeat (2) stepCycle();
        reset = 0;
        repeat (6) stepCycle();

        // Random mix of hw reads, CPU READ/READCLEAR and checker errors.
        for (int k = 0; k < 400; k++) begin
            hwRead = 1'($urandom_range(0, 1));
            hwAddr = 10'h020 + AW'($urandom_range(0, 3));
            uncErr = NW'($urandom);
            corErr = NW'($urandom);
            if (!cpuReq && $urandom_range(0, 3) == 0)
                request(1'($urandom_range(0, 1)), 10'h020 + AW'($urandom_range(0, 3)));
            stepCycle();
        end
        hwRead = 0;
        runUntilIdle("randomDrain", 300);
        repeat (4) stepCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
